// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (16x oversampling) feeding a small
// show-ahead receive FIFO with sticky overrun and framing-error flags.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, plus a sticky parity_err output.
module uart_rx_fifo #(
  parameter int clk_freq = 50000000,
  parameter int baud     = 19200,
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            rd_en,
  input  logic            clr_err,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            overrun,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            frame_err
);

  localparam int DVSR = clk_freq / (baud * 16);
  localparam int TW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rxStateT;

  logic            rxSync1, rxSync2;
  logic [TW-1:0]   tickCnt;
  logic            sTick;

  rxStateT         state, stateNext;
  logic [3:0]      sCnt, sNext;
  logic [NW-1:0]   nCnt, nNext;
  logic [DBIT-1:0] shiftReg, shiftNext;
  logic            pushReq;
  logic            frameErrEv;
`ifdef UART_RX_PARITY_EN
  logic            parityBad, parityBadNext;
  logic            parityErrEv;
`endif

  logic [DBIT-1:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wptr, rptr, wptrSucc, rptrSucc;
  logic              fullReg, emptyReg;
  logic              wrOk, rdOk, overrunEv;

  // Bring the asynchronous serial line into the clock domain; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
    end else begin
      rxSync1 <= rx;
      rxSync2 <= rxSync1;
    end
  end

  assign sTick = (tickCnt == TW'(DVSR - 1));

  // Free-running 16x baud tick divider; never re-aligned to the start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tickCnt <= '0;
    else      tickCnt <= sTick ? '0 : tickCnt + TW'(1);
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sCnt     <= '0;
      nCnt     <= '0;
      shiftReg <= '0;
`ifdef UART_RX_PARITY_EN
      parityBad <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      sCnt     <= sNext;
      nCnt     <= nNext;
      shiftReg <= shiftNext;
`ifdef UART_RX_PARITY_EN
      parityBad <= parityBadNext;
`endif
    end
  end

  // Frame sequencing: mid-bit sampling at tick 7 of start, 15 of each later bit.
  always_comb begin
    stateNext  = state;
    sNext      = sCnt;
    nNext      = nCnt;
    shiftNext  = shiftReg;
    pushReq    = 1'b0;
    frameErrEv = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBadNext = parityBad;
    parityErrEv   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxSync2) begin
          stateNext = START;
          sNext     = '0;
        end
      end
      START: begin
        if (sTick) begin
          if (sCnt == 4'd7) begin
            if (!rxSync2) begin
              stateNext = DATA;
              sNext     = '0;
              nNext     = '0;
`ifdef UART_RX_PARITY_EN
              parityBadNext = 1'b0;
`endif
            end else begin
              stateNext = IDLE;
            end
          end else begin
            sNext = sCnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (sTick) begin
          if (sCnt == 4'd15) begin
            sNext     = '0;
            shiftNext = {rxSync2, shiftReg[DBIT-1:1]};
            if (nCnt == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              stateNext = PARITY;
`else
              stateNext = STOP;
`endif
            end else begin
              nNext = nCnt + NW'(1);
            end
          end else begin
            sNext = sCnt + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sTick) begin
          if (sCnt == 4'd15) begin
            sNext     = '0;
            stateNext = STOP;
            if ((^shiftReg) != rxSync2) begin
              parityBadNext = 1'b1;
              parityErrEv   = 1'b1;
            end
          end else begin
            sNext = sCnt + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (sTick) begin
          if (sCnt == 4'd15) begin
            stateNext = IDLE;
            if (rxSync2) begin
`ifdef UART_RX_PARITY_EN
              pushReq = !parityBad;
`else
              pushReq = 1'b1;
`endif
            end else begin
              frameErrEv = 1'b1;
            end
          end else begin
            sNext = sCnt + 4'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign rdOk      = rd_en && !emptyReg;
  assign wrOk      = pushReq && (!fullReg || rdOk);
  assign overrunEv = pushReq && fullReg && !rdOk;
  assign wptrSucc  = wptr + ADDR_W'(1);
  assign rptrSucc  = rptr + ADDR_W'(1);

  // FIFO storage; contents are only visible while not empty, so no reset.
  always_ff @(posedge clk) begin
    if (wrOk) mem[wptr] <= shiftReg;
  end

  // Pointers with registered full/empty flags; simultaneous push+pop keeps both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fullReg  <= 1'b0;
      emptyReg <= 1'b1;
    end else begin
      case ({wrOk, rdOk})
        2'b10: begin
          wptr     <= wptrSucc;
          emptyReg <= 1'b0;
          fullReg  <= (wptrSucc == rptr);
        end
        2'b01: begin
          rptr     <= rptrSucc;
          fullReg  <= 1'b0;
          emptyReg <= (rptrSucc == wptr);
        end
        2'b11: begin
          wptr <= wptrSucc;
          rptr <= rptrSucc;
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags: a new event in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun   <= (overrun && !clr_err) || overrunEv;
      frame_err <= (frame_err && !clr_err) || frameErrEv;
`ifdef UART_RX_PARITY_EN
      parity_err <= (parity_err && !clr_err) || parityErrEv;
`endif
    end
  end

  assign r_data   = emptyReg ? '0 : mem[rptr];
  assign rx_empty = emptyReg;
  assign rx_full  = fullReg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed serial frames into uart_rx_fifo, checked every
// cycle against a frame-level receiver model and a queue-based FIFO model.
// Built for the default 8N1 configuration (UART_RX_PARITY_EN undefined).
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1200000;
  localparam int BAUD     = 15000;
  localparam int DVSR     = CLK_FREQ / (BAUD * 16);
  localparam int BIT      = DVSR * 16;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] r_data;
  logic       rx_empty, rx_full, overrun, frame_err;

  int checkCount = 0;
  int passCount  = 0;

  uart_rx_fifo #(
    .clk_freq(CLK_FREQ),
    .baud(BAUD),
    .DBIT(8),
    .ADDR_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd_en(rd_en),
    .clr_err(clr_err),
    .r_data(r_data),
    .rx_empty(rx_empty),
    .rx_full(rx_full),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: ticks every DVSR clocks, line seen 2 clocks late,
  // samples at ticks 8 (start), 24..136 (data, LSB first), 152 (stop).
  int         mEdge = 0;
  int         mTicks = 0;
  logic       mS1 = 1'b1, mS2 = 1'b1, mBusy = 1'b0;
  logic       mLine, mTick, mPush, mPopOk;
  logic [7:0] mByte = 8'h00;
  logic [7:0] mQ[$];
  logic       mOvr = 1'b0, mFerr = 1'b0;

  // Model advances once per clock; asynchronous reset clears everything.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mEdge = 0; mTicks = 0; mS1 = 1'b1; mS2 = 1'b1; mBusy = 1'b0;
      mByte = 8'h00; mQ.delete(); mOvr = 1'b0; mFerr = 1'b0;
    end else begin
      mTick = ((mEdge % DVSR) == DVSR - 1);
      mLine = mS2;
      mPush = 1'b0;
      mEdge++;
      mS2 = mS1;
      mS1 = rx;
      if (clr_err) begin mOvr = 1'b0; mFerr = 1'b0; end
      if (!mBusy) begin
        if (!mLine) begin mBusy = 1'b1; mTicks = 0; end
      end else if (mTick) begin
        mTicks++;
        if (mTicks == 8) begin
          if (mLine) mBusy = 1'b0;
        end else if (mTicks >= 24 && mTicks <= 136 && (mTicks % 16) == 8) begin
          mByte[(mTicks - 24) / 16] = mLine;
        end else if (mTicks == 152) begin
          mBusy = 1'b0;
          if (mLine) mPush = 1'b1;
          else       mFerr = 1'b1;
        end
      end
      mPopOk = rd_en && (mQ.size() > 0);
      if (mPopOk) void'(mQ.pop_front());
      if (mPush) begin
        if (mQ.size() < DEPTH) mQ.push_back(mByte);
        else                   mOvr = 1'b1;
      end
    end
  end

  logic       litPending = 1'b0;
  string      litName;
  int         litWhich;
  logic [7:0] litExp, litAct;
  logic       timeoutHit = 1'b0;
  logic [11:0] expVec, actVec;

  // Single compare process: full output check each cycle plus literal pins.
  always @(negedge clk) begin
    expVec = {(mQ.size() > 0) ? mQ[0] : 8'h00, mQ.size() == 0, mQ.size() == DEPTH, mOvr, mFerr};
    actVec = {r_data, rx_empty, rx_full, overrun, frame_err};
    checkCount++;
    if (actVec === expVec) passCount++;
    else $display("[TB] FAIL outputs @%0t: actual {data,empty,full,ovr,ferr}=%h required=%h",
                  $time, actVec, expVec);
    if (litPending) begin
      case (litWhich)
        0:       litAct = r_data;
        1:       litAct = {7'b0, rx_empty};
        2:       litAct = {7'b0, rx_full};
        3:       litAct = {7'b0, overrun};
        4:       litAct = {7'b0, frame_err};
        5:       litAct = {7'b0, timeoutHit};
        default: litAct = 8'hxx;
      endcase
      checkCount++;
      if (litAct === litExp) passCount++;
      else $display("[TB] FAIL %s: actual=%h required=%h", litName, litAct, litExp);
    end
  end

  task automatic checkOutput(input string name, input int which, input logic [7:0] exp);
    @(posedge clk);
    litName = name; litWhich = which; litExp = exp; litPending = 1'b1;
    @(negedge clk);
    #1 litPending = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopLow);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx = frame[i];
      repeat (BIT) @(negedge clk);
    end
    if (stopLow) begin
      rx = 1'b0;
      repeat (BIT * 7 / 10) @(negedge clk);
      rx = 1'b1;
      repeat (BIT - BIT * 7 / 10) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic popOne();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clearErrors();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic popAtPush();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 20 * BIT && !done; c++) begin
      @(negedge clk);
      if (mBusy && mTicks == 151 && (mEdge % DVSR) == DVSR - 1) begin
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) timeoutHit = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("resetEmpty", 1, 8'h01);
    checkOutput("resetData", 0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    applyStimulus(8'h55, 1'b0);
    checkOutput("byte55Data", 0, 8'h55);
    checkOutput("byte55NotEmpty", 1, 8'h00);
    popOne();
    checkOutput("popEmpty", 1, 8'h01);
    checkOutput("popDataZero", 0, 8'h00);
    popOne();
    checkOutput("popWhileEmpty", 1, 8'h01);

    @(negedge clk);
    rx = 1'b0;
    repeat (3 * DVSR) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    checkOutput("glitchEmpty", 1, 8'h01);
    checkOutput("glitchNoFerr", 4, 8'h00);
    checkOutput("glitchNoOvr", 3, 8'h00);

    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("fillFull", 2, 8'h01);
    checkOutput("fillOverrun", 3, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("fillReadOrder", 0, 8'(i));
      popOne();
    end
    checkOutput("fillDrained", 1, 8'h01);
    checkOutput("overrunSticky", 3, 8'h01);
    clearErrors();
    checkOutput("overrunCleared", 3, 8'h00);

    applyStimulus(8'hA3, 1'b1);
    checkOutput("frameErrSet", 4, 8'h01);
    checkOutput("frameErrNoPush", 1, 8'h01);
    applyStimulus(8'h3C, 1'b0);
    checkOutput("afterFrameErrData", 0, 8'h3C);
    popOne();
    clearErrors();
    checkOutput("frameErrCleared", 4, 8'h00);

    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h20, 1'b0);
    applyStimulus(8'h30, 1'b0);
    applyStimulus(8'h40, 1'b0);
    checkOutput("preloadFull", 2, 8'h01);
    fork
      applyStimulus(8'h77, 1'b0);
      popAtPush();
    join
    checkOutput("pushPopTimeout", 5, 8'h00);
    checkOutput("pushPopFull", 2, 8'h01);
    checkOutput("pushPopNoOvr", 3, 8'h00);
    checkOutput("pushPopHead20", 0, 8'h20); popOne();
    checkOutput("pushPopHead30", 0, 8'h30); popOne();
    checkOutput("pushPopHead40", 0, 8'h40); popOne();
    checkOutput("pushPopLast77", 0, 8'h77); popOne();
    checkOutput("pushPopDrained", 1, 8'h01);

    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10 * BIT) @(negedge clk);
    checkOutput("abortNoPush", 1, 8'h01);
    applyStimulus(8'h12, 1'b0);
    checkOutput("afterResetData", 0, 8'h12);
    checkOutput("afterResetNoOvr", 3, 8'h00);
    checkOutput("afterResetNoFerr", 4, 8'h00);
    popOne();
    checkOutput("afterResetDrained", 1, 8'h01);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front-end of the IO path: 8N1 UART receiver with 16x oversampling plus a small show-ahead receive FIFO.
- Sits directly upstream of the IO-memory / IO multiplexer stage in system, which reads bytes from it with a one-cycle pop strobe.
- Replaces the ad-hoc echo UART receive path with a block that has defined overflow and framing-error reporting.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud, 19200, line rate in bit/s.
- DBIT, 8, data bits per frame.
- ADDR_W, 2, FIFO address width; depth = 2**ADDR_W (default 4 entries).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_en  input  1  pop strobe, one byte per cycle high.
- clr_err  input  1  clears sticky error flags.
- r_data  output  DBIT  head-of-FIFO byte (show-ahead).
- rx_empty  output  1  FIFO empty.
- rx_full  output  1  FIFO full.
- overrun  output  1  sticky: byte dropped because FIFO full.
- frame_err  output  1  sticky: stop bit sampled low.

Behaviour:
- Reset (rst=0, asynchronous) sets outputs as follows:
  - r_data=0, rx_empty=1, rx_full=0, overrun=0, frame_err=0.
  - FSM goes to IDLE; pointers, tick counter and sync flops are cleared; sync flops reset to 1.
  - Reset mid-frame abandons the frame; nothing is pushed.
- rx passes through a 2-flop synchronizer, adding 2 cycles of latency.
- Tick generator:
  - DVSR = clk_freq/(baud*16), integer division (162 at defaults).
  - Counter runs 0..DVSR-1 and asserts s_tick for one cycle at DVSR-1, then wraps to 0.
  - The counter is free-running and not re-aligned by the start edge.
- FSM states and transitions (s = tick count within state, n = bit index):
  - IDLE: on synchronized rx=0 -> START with s=0.
  - START: on s_tick with s=7, check rx. If rx=0 -> DATA with s=0, n=0. If rx=1 -> IDLE (glitch rejected, no flag set). Otherwise s++ on each tick.
  - DATA: on s_tick with s=15, shift rx into the MSB of the shift register (LSB-first line order) and reset s=0. When n=DBIT-1 -> STOP, else n++.
  - STOP: on s_tick with s=15, go to IDLE. If rx=1, issue a push request (one cycle). If rx=0, set frame_err and discard the byte.
- FIFO:
  - r_data = mem[rptr] when not empty, 0 when empty (combinational from registered state).
  - Pop (rd_en=1 and not empty): rptr++ next cycle. rd_en while empty is ignored, pointers unchanged.
  - Push while not full: write mem[wptr], wptr++. Push while full and no pop: byte dropped, overrun=1.
  - Push and pop in the same cycle: both succeed, even when full; count unchanged, flags unchanged.
  - Pointers wrap modulo depth. Full/empty are tracked with registered flags updated alongside the pointers.
  - rx_empty deasserts the cycle after the push cycle.
- Sticky flags:
  - Cleared by clr_err=1.
  - If clr_err and a new error event fall in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - FSM gains a PARITY state between DATA and STOP, sampled at s=15.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by clr_err).
  - Even parity is expected. On mismatch, parity_err=1 and the byte is discarded at STOP.
- When undefined: no PARITY state, no parity_err port, frame is 8N1.

Test Plan:
- Send 0x55 at 19200 baud (2592 clk per bit) -> rx_empty falls about 10 bit-times after the start edge; r_data=0x55; rd_en pulse -> rx_empty=1, r_data=0x00.
- Drive rx low for 3 ticks (486 clk) then high -> FSM returns to IDLE, rx_empty stays 1, no flags set.
- Send 0x01,0x02,0x03,0x04,0x05 with no reads (depth 4):
  - rx_full=1 after the 4th byte; 5th byte dropped; overrun=1.
  - Reads return 0x01..0x04 in order, then rx_empty=1.
  - clr_err -> overrun=0.
- Send 0xA3 with stop bit forced low -> frame_err=1, rx_empty stays 1. A following good 0x3C is received normally.
- With FIFO full, assert rd_en in the same cycle as the push of 0x77 -> rx_full stays 1, overrun=0; 0x77 is read last.
- Assert rst=0 mid-DATA of byte 0xFF, release, send 0x12 -> only 0x12 appears; all flags 0.
